// File: rtl/store_commit_unit_pkg.sv
// Shared constants and types for the store commit path: op-type encodings,
// ROB tag type, store widths, slot record and writer FSM states.
package store_commit_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned ENTRY_W = 4;
  typedef logic [ENTRY_W-1:0] entry_t;

  localparam logic [2:0] SType = 3'b011;

  localparam logic [1:0] WIDTH_B = 2'd0;
  localparam logic [1:0] WIDTH_H = 2'd1;
  localparam logic [1:0] WIDTH_W = 2'd2;

  // addr[17:16] value of the memory-mapped I/O window
  localparam logic [1:0] IO_REGION_HI = 2'b11;

  typedef struct packed {
    entry_t      tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } slot_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WRITE,
    W_DONE
  } wr_state_e;

  function automatic logic [1:0] last_byte(input logic [1:0] width);
    logic [1:0] r;
    case (width)
      WIDTH_B: r = 2'd0;
      WIDTH_H: r = 2'd1;
      WIDTH_W: r = 2'd3;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_commit_unit_if.sv
// Byte-wide memory write port between the store commit unit and the arbiter.
interface store_commit_unit_if;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output mem_req, mem_a, mem_dout, mem_wr,
    input  mem_grant, io_buffer_full
  );

  modport slave (
    input  mem_req, mem_a, mem_dout, mem_wr,
    output mem_grant, io_buffer_full
  );
endinterface

// File: rtl/store_commit_unit_byte_writer.sv
// Serialises one committed store into byte writes: request the port, emit
// 1/2/4 bytes (stalling on a full I/O sink), then pulse finish.
module store_byte_writer
  import store_commit_unit_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_REGION_HI
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rdy_i,
  input  logic        roll_back_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  width_i,
  output logic        idle_o,
  output logic        done_o,
  output logic        finish_o,
  store_commit_unit_if.master mem
);

  wr_state_e   state_q;
  logic [31:0] addr_q, data_q, a_q;
  logic [7:0]  dout_q;
  logic [1:0]  k_q, last_q;
  logic        io_q, kill_q, req_q, wr_q, finish_q;

  logic       blocked;
  logic [1:0] k_nx;

  assign blocked = io_q && mem.io_buffer_full;
  assign k_nx    = k_q + 2'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= W_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      k_q      <= '0;
      last_q   <= '0;
      io_q     <= 1'b0;
      kill_q   <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      finish_q <= 1'b0;
    end else if (rdy_i) begin
      case (state_q)
        W_IDLE: begin
          if (start_i) begin
            addr_q  <= addr_i;
            data_q  <= data_i;
            last_q  <= last_byte(width_i);
            io_q    <= (addr_i[17:16] == IO_ADDR_HI);
            kill_q  <= roll_back_i;
            req_q   <= 1'b1;
            state_q <= W_REQ;
          end
        end
        W_REQ: begin
          kill_q <= kill_q || roll_back_i;
          if (mem.mem_grant) begin
            k_q     <= '0;
            a_q     <= addr_q;
            dout_q  <= data_q[7:0];
            wr_q    <= 1'b1;
            state_q <= W_WRITE;
          end
        end
        W_WRITE: begin
          kill_q <= kill_q || roll_back_i;
          if (!blocked) begin
            if (k_q == last_q) begin
              // A rollback seen at any point of this store hides its finish
              wr_q     <= 1'b0;
              req_q    <= 1'b0;
              finish_q <= !(kill_q || roll_back_i);
              state_q  <= W_DONE;
            end else begin
              k_q    <= k_nx;
              a_q    <= addr_q + {30'd0, k_nx};
              dout_q <= 8'(data_q >> {k_nx, 3'b000});
            end
          end
        end
        W_DONE: begin
          finish_q <= 1'b0;
          state_q  <= W_IDLE;
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_a    = a_q;
  assign mem.mem_dout = dout_q;
  assign mem.mem_wr   = wr_q && rdy_i && !blocked;

  assign idle_o   = (state_q == W_IDLE);
  assign done_o   = (state_q == W_DONE);
  assign finish_o = finish_q;

endmodule

// File: rtl/store_commit_unit.sv
// Addressed-store slot table with commit tag match, one-deep pending commit
// and rollback; the byte writer performs the actual memory writes.
module store_commit_unit
  import store_commit_unit_pkg::*;
#(
  parameter int unsigned SQ_DEPTH   = 8,
  parameter logic [1:0]  IO_ADDR_HI = IO_REGION_HI
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        lsb_store_addressed,
  input  entry_t      lsb_store_entry,
  input  logic [31:0] lsb_store_addr,
  input  logic [31:0] lsb_store_data,
  input  logic [1:0]  lsb_store_width,
  input  logic        rob_commit,
  input  logic [2:0]  rob_op_type_commit,
  input  entry_t      rob_entry_commit,
  output logic        finish_store,
  output logic        sq_full,
  store_commit_unit_if.master mem
);

  localparam int unsigned IDX_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(SQ_DEPTH + 1);
  typedef logic [IDX_W-1:0] idx_t;

  logic [SQ_DEPTH-1:0] valid_q, valid_d, cmt_q, cmt_d;
  slot_t               slot_q [SQ_DEPTH];

  idx_t alloc_idx, cm_idx, pend_idx_q, pend_idx_d, cur_q, start_idx;
  logic alloc_ok, cm_hit, cm_fire, do_alloc;
  logic pend_v_q, pend_v_d, start, idle, done;
  logic sq_full_q, sq_full_d;
  logic [CNT_W-1:0] free_cnt;

  always_comb begin
    alloc_ok  = FALSE;
    alloc_idx = '0;
    cm_hit    = FALSE;
    cm_idx    = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (!valid_q[i] && !alloc_ok) begin
        alloc_ok  = TRUE;
        alloc_idx = idx_t'(i);
      end
      if (valid_q[i] && !cmt_q[i] && slot_q[i].tag == rob_entry_commit) begin
        cm_hit = TRUE;
        cm_idx = idx_t'(i);
      end
    end
  end

  assign cm_fire   = rob_commit && (rob_op_type_commit == SType) && cm_hit;
  assign do_alloc  = lsb_store_addressed && alloc_ok && !roll_back;
  assign start     = idle && (pend_v_q || cm_fire);
  assign start_idx = pend_v_q ? pend_idx_q : cm_idx;

  // A queued commit always goes first; a new commit then takes its place
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_idx_d = pend_idx_q;
    if (start && pend_v_q) pend_v_d = FALSE;
    if (cm_fire && (!idle || pend_v_q)) begin
      pend_v_d   = TRUE;
      pend_idx_d = cm_idx;
    end
  end

  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    if (cm_fire) cmt_d[cm_idx] = TRUE;
    if (done) begin
      valid_d[cur_q] = FALSE;
      cmt_d[cur_q]   = FALSE;
    end
    if (roll_back) begin
      valid_d = valid_d & cmt_d;
    end else if (do_alloc) begin
      valid_d[alloc_idx] = TRUE;
      cmt_d[alloc_idx]   = FALSE;
    end
    free_cnt = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      free_cnt = free_cnt + CNT_W'(!valid_d[i]);
    end
    sq_full_d = (free_cnt <= CNT_W'(1));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q    <= '0;
      cmt_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_idx_q <= '0;
      cur_q      <= '0;
      sq_full_q  <= 1'b0;
    end else if (rdy_in) begin
      valid_q    <= valid_d;
      cmt_q      <= cmt_d;
      pend_v_q   <= pend_v_d;
      pend_idx_q <= pend_idx_d;
      sq_full_q  <= sq_full_d;
      if (start) cur_q <= start_idx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && do_alloc) begin
      slot_q[alloc_idx] <= '{tag:   lsb_store_entry,
                             addr:  lsb_store_addr,
                             data:  lsb_store_data,
                             width: lsb_store_width};
    end
  end

  store_byte_writer #(
    .IO_ADDR_HI(IO_ADDR_HI)
  ) u_writer (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .rdy_i      (rdy_in),
    .roll_back_i(roll_back),
    .start_i    (start),
    .addr_i     (slot_q[start_idx].addr),
    .data_i     (slot_q[start_idx].data),
    .width_i    (slot_q[start_idx].width),
    .idle_o     (idle),
    .done_o     (done),
    .finish_o   (finish_store),
    .mem        (mem)
  );

  assign sq_full = sq_full_q;

endmodule

// File: doc/store_commit_unit.md
# store_commit_unit

Write-back end of the ROB store protocol: holds stores the LSB has addressed, waits for the ROB to commit each one, then serialises it into byte writes on the shared 8-bit memory port and answers with `finish_store`. Sits between the LSB, the ROB commit broadcast and the memory arbiter; it is the only agent that writes memory.

## Interface
Parameters:
- `SQ_DEPTH`, 8: addressed-store slots.
- `IO_ADDR_HI`, 2'b11: `addr[17:16]` value marking the I/O region, where writes honour `io_buffer_full`.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: pause when low.
- `roll_back` in 1: branch-mispredict flush.
- `lsb_store_addressed` in 1: store's address and data are known.
- `lsb_store_entry` in `ENTRY_RANGE`: ROB tag.
- `lsb_store_addr` in 32: byte address.
- `lsb_store_data` in 32: data, little-endian.
- `lsb_store_width` in 2: 0 byte, 1 half, 2 word.
- `rob_commit` in 1: ROB commit strobe.
- `rob_op_type_commit` in 3: op type; only `SType` is acted on.
- `rob_entry_commit` in `ENTRY_RANGE`: committed tag.
- `finish_store` out 1: one-cycle pulse, committed store fully written.
- `sq_full` out 1: LSB must not present new addressed stores.
- `mem_req` out 1: request to the memory arbiter.
- `mem_grant` in 1: arbiter grant.
- `mem_a` out 32: byte address.
- `mem_dout` out 8: write byte.
- `mem_wr` out 1: write strobe.
- `io_buffer_full` in 1: I/O sink cannot take a byte.

## Operation
- Slot table of `SQ_DEPTH` entries: valid, tag, addr, data, width. `lsb_store_addressed` fills the lowest free slot.
- Commit (`rob_commit && op_type==SType`) matches the slot by tag and marks it committed.
  - If the writer is busy, the slot index is put in a one-deep pending register. The ROB holds a second store commit until `finish_store`, so that register never overflows.
  - A commit with no matching slot is a protocol violation; the bench asserts on it.
- Writer FSM:
  - IDLE: take the pending or just-committed slot → REQ.
  - REQ: `mem_req`=1 and wait for `mem_grant` → WRITE.
  - WRITE: byte counter k = 0..n-1, n = 1/2/4 by width. Drive `mem_a` = addr+k (32-bit wrap), `mem_dout` = data[8k+7:8k], `mem_wr`=1. In the I/O region, while `io_buffer_full`=1: no write, k holds. After the last byte → DONE.
  - DONE: pulse `finish_store`, drop `mem_req`, free the slot → IDLE.
- `roll_back`:
  - Invalidates every uncommitted slot.
  - A write in flight completes, but its `finish_store` is suppressed (the ROB clears `is_storing` on `roll_back`), so a later store is never released early.
  - Pending committed slots are kept.
- `rdy_in` low: all state frozen, `mem_wr` forced 0, k holds.
- Simultaneous addressed and commit for different tags: both take effect in the same cycle. Same tag in the same cycle cannot occur, because the ROB sees ready one cycle after addressed.
- `sq_full` (registered) = free slots ≤ 1. This covers the LSB's one-cycle reaction delay.

## Timing
- Reset values: `finish_store`, `sq_full`, `mem_req`, `mem_wr` = 0; `mem_a`, `mem_dout` = 0; FSM in IDLE; all slots invalid; pending empty.
- Commit sampled at edge T → `mem_req`=1 from T+1.
- Grant sampled high at edge G → bytes on G+1..G+n.
- `finish_store` high for cycle G+n+1 only; `mem_req` low from that cycle.
- Word store with immediate grant: commit → `finish_store` = 6 cycles.
- A slot freed at DONE can be reallocated in the next cycle.

## Structure
- `operaType.v` holds `SType`, `TRUE`/`FALSE` and `ENTRY_RANGE`.
- Add to `operaType.v`: `WIDTH_B`/`WIDTH_H`/`WIDTH_W` and the I/O region constant.
- Sub-module `store_byte_writer` holds the REQ/WRITE/DONE FSM and byte counter. The top holds the slot table, tag match, pending register and rollback logic.

## Test plan
- Word store: addr 0x1000, data 0xDEADBEEF; commit with immediate grant → writes EF@1000, BE@1001, AD@1002, DE@1003, then one `finish_store` pulse 6 cycles after commit.
- Half store to 0x30000 with `io_buffer_full` high for 3 cycles → first byte held 3 cycles, then 2 writes; exactly one `finish_store`.
- Fill 7 slots → `sq_full`=1; commit one and finish → `sq_full` returns to 0 the cycle after the slot frees.
- `roll_back` mid-WRITE with 3 uncommitted slots → write completes, no `finish_store`, all 3 slots freed.
- Back-to-back: second commit during the first write → pending latched; second write starts after the first DONE; two `finish_store` pulses.
- Async reset asserted mid-WRITE → `mem_wr`/`mem_req` drop to 0 immediately; no `finish_store` after release.
